uart_line_parser: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/ascii_classify.sv | 28 ++
 rtl/uart_line_parser.sv | 152 +++++++++++++++
 tb/tb_uart_line_parser.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, parser state encoding and error codes.
package uart_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_X_LO = 8'h78;
  localparam logic [7:0] ASCII_X_UP = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEC,
    ST_HEX,
    ST_DISCARD
  } parse_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BADCHAR  = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_EMPTY    = 2'd3
  } err_code_t;

endpackage

// File: rtl/ascii_classify.sv
// Combinational byte classifier: digit / hex / terminator / space, plus nibble value.
module ascii_classify
  import uart_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_digit,
  output logic       o_is_hex,
  output logic       o_is_term,
  output logic       o_is_space,
  output logic [3:0] o_nibble
);

  logic w_lc;
  logic w_uc;

  assign o_is_digit = (i_byte >= ASCII_0) && (i_byte <= ASCII_9);
  assign w_lc       = (i_byte >= 8'h61) && (i_byte <= 8'h66);
  assign w_uc       = (i_byte >= 8'h41) && (i_byte <= 8'h46);
  assign o_is_hex   = o_is_digit | w_lc | w_uc;
  assign o_is_term  = (i_byte == ASCII_CR) || (i_byte == ASCII_LF);
  assign o_is_space = (i_byte == ASCII_SP);

  // 'a'/'A' have low nibble 1, so letters map to low nibble + 9
  assign o_nibble = o_is_digit  ? i_byte[3:0] :
                    (w_lc|w_uc) ? i_byte[3:0] + 4'd9 :
                                  4'd0;

endmodule

// File: rtl/uart_line_parser.sv
// Decimal line parser for uart_rx bytes; hex lines ("x..") with UART_LINE_PARSER_HEX_EN.
module uart_line_parser
  import uart_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       received,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  parse_state_t r_state;
  logic [9:0]   r_acc;
  logic [1:0]   r_cnt;
  logic [7:0]   r_value;
  logic         r_vv;
  logic         r_err;
  err_code_t    r_code;

  logic         w_is_digit;
  logic         w_is_term;
  logic         w_is_space;
  logic [3:0]   w_nibble;
  logic [11:0]  w_dec_next;
  logic         w_dec_ovf;
`ifdef UART_LINE_PARSER_HEX_EN
  logic         w_is_hex;
  logic         w_is_x;

  assign w_is_x = (rx_data == ASCII_X_LO) || (rx_data == ASCII_X_UP);
`endif

  ascii_classify u_cls (
    .i_byte     (rx_data),
    .o_is_digit (w_is_digit),
`ifdef UART_LINE_PARSER_HEX_EN
    .o_is_hex   (w_is_hex),
`else
    .o_is_hex   (),
`endif
    .o_is_term  (w_is_term),
    .o_is_space (w_is_space),
    .o_nibble   (w_nibble)
  );

  // acc*10 + digit kept at 12 bits so values past 1023 still compare correctly
  assign w_dec_next = ({2'b0, r_acc} << 3)
                    + ({2'b0, r_acc} << 1)
                    + {8'b0, w_nibble};
  assign w_dec_ovf  = (w_dec_next > 12'd255)
                    || (r_cnt == 2'(MAX_DIGITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_value <= '0;
      r_vv    <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
    end else begin
      r_vv  <= 1'b0;
      r_err <= 1'b0;
      if (received) begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_is_digit) begin
              r_acc   <= {6'b0, w_nibble};
              r_cnt   <= 2'd1;
              r_state <= ST_DEC;
`ifdef UART_LINE_PARSER_HEX_EN
            end else if (w_is_x) begin
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= ST_HEX;
`endif
            end else if (!(w_is_term || w_is_space)) begin
              r_err   <= 1'b1;
              r_code  <= ERR_BADCHAR;
              r_state <= ST_DISCARD;
            end
          end
          ST_DEC: begin
            if (w_is_digit) begin
              if (w_dec_ovf) begin
                r_err   <= 1'b1;
                r_code  <= ERR_OVERFLOW;
                r_state <= ST_DISCARD;
              end else begin
                r_acc <= w_dec_next[9:0];
                r_cnt <= r_cnt + 2'd1;
              end
            end else if (w_is_term) begin
              r_value <= r_acc[7:0];
              r_vv    <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_code  <= ERR_BADCHAR;
              r_state <= ST_DISCARD;
            end
          end
`ifdef UART_LINE_PARSER_HEX_EN
          ST_HEX: begin
            if (w_is_hex) begin
              if (r_cnt == 2'd2) begin
                r_err   <= 1'b1;
                r_code  <= ERR_OVERFLOW;
                r_state <= ST_DISCARD;
              end else begin
                r_acc <= {2'b0, r_acc[3:0], w_nibble};
                r_cnt <= r_cnt + 2'd1;
              end
            end else if (w_is_term) begin
              if (r_cnt == 2'd0) begin
                r_err  <= 1'b1;
                r_code <= ERR_EMPTY;
              end else begin
                r_value <= r_acc[7:0];
                r_vv    <= 1'b1;
              end
              r_state <= ST_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_code  <= ERR_BADCHAR;
              r_state <= ST_DISCARD;
            end
          end
`endif
          ST_DISCARD: begin
            if (w_is_term) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign value       = r_value;
  assign value_valid = r_vv;
  assign err         = r_err;
  assign err_code    = r_code;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_line_parser.sv
// Randomized bench for uart_line_parser against a line-level reference model.
module tb_uart_line_parser;

  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       received = 1'b0;
  logic [7:0] value;
  logic       value_valid;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int checks = 0;
  int passed = 0;
  int both_cnt = 0;

  // event word: {kind, data}; kind 1 = value, kind 2 = error code
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] line_q[$];
  logic [7:0] exp_value = 8'h00;
  logic [1:0] exp_code = 2'd0;

  uart_line_parser #(.MAX_DIGITS(MAXD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .received    (received),
    .value       (value),
    .value_valid (value_valid),
    .err         (err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (value_valid) got_q.push_back({2'd1, value});
      if (err) got_q.push_back({2'd2, 6'd0, err_code});
      if (value_valid && err) both_cnt++;
    end
  end

  function automatic void exp_err(input int code);
    exp_q.push_back({2'd2, 6'd0, 2'(code)});
    exp_code = 2'(code);
  endfunction

  function automatic void exp_val(input int v);
    exp_q.push_back({2'd1, 8'(v)});
    exp_value = 8'(v);
  endfunction

  // one complete line (terminator stripped) -> at most one expected event
  function automatic void model_line();
    int n = line_q.size();
    int i = 0;
    int v = 0;
    int d = 0;
    int c;
    while (i < n && line_q[i] == 8'h20) i++;
    if (i == n) return;
`ifdef UART_LINE_PARSER_HEX_EN
    if (line_q[i] == 8'h78 || line_q[i] == 8'h58) begin
      for (i = i + 1; i < n; i++) begin
        c = int'(line_q[i]);
        if (c >= 48 && c <= 57) c = c - 48;
        else if (c >= 97 && c <= 102) c = c - 87;
        else if (c >= 65 && c <= 70) c = c - 55;
        else begin
          exp_err(1);
          return;
        end
        if (d == 2) begin
          exp_err(2);
          return;
        end
        v = v * 16 + c;
        d++;
      end
      if (d == 0) exp_err(3);
      else exp_val(v);
      return;
    end
`endif
    for (; i < n; i++) begin
      c = int'(line_q[i]);
      if (c >= 48 && c <= 57) begin
        if (d == MAXD || v * 10 + (c - 48) > 255) begin
          exp_err(2);
          return;
        end
        v = v * 10 + (c - 48);
        d++;
      end else begin
        exp_err(1);
        return;
      end
    end
    exp_val(v);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'h0D || b == 8'h0A) begin
      model_line();
      line_q.delete();
    end else begin
      line_q.push_back(b);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    received = 1'b1;
    @(posedge clk);
    #1;
    received = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic play(input string s, input int gapmax);
    for (int i = 0; i < s.len(); i++) begin
      model_byte(s[i]);
      send_byte(s[i], $urandom_range(gapmax, 0));
    end
  endtask

  task automatic settle();
    received = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_random_line(input int gapmax);
    int len;
    int r;
    logic [7:0] b;
    len = $urandom_range(4, 0);
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(99, 0);
      if (r < 70) b = 8'(48 + $urandom_range(9, 0));
      else if (r < 78) b = 8'h20;
      else if (r < 84) b = ($urandom_range(1, 0) == 1) ? 8'h78 : 8'h58;
      else if (r < 92) b = 8'(97 + $urandom_range(7, 0));
      else b = 8'(65 + $urandom_range(7, 0));
      model_byte(b);
      send_byte(b, $urandom_range(gapmax, 0));
    end
    r = $urandom_range(2, 0);
    if (r != 1) begin
      model_byte(8'h0D);
      send_byte(8'h0D, $urandom_range(gapmax, 0));
    end
    if (r != 0) begin
      model_byte(8'h0A);
      send_byte(8'h0A, $urandom_range(gapmax, 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (value !== 8'h00) $display("FAIL reset_value got %h want 00", value);
    else passed++;
    checks++;
    if (value_valid !== 1'b0) $display("FAIL reset_vv got %b want 0", value_valid);
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err);
    else passed++;
    checks++;
    if (err_code !== 2'd0) $display("FAIL reset_code got %0d want 0", err_code);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_busy();
    string s = "123\015";
    for (int i = 0; i < 4; i++) begin
      model_byte(s[i]);
      send_byte(s[i], 0);
      checks++;
      if (busy !== (i < 3)) $display("FAIL busy_%0d got %b want %b", i, busy, i < 3);
      else passed++;
    end
    checks++;
    if (value_valid !== 1'b1 || value !== 8'h7B)
      $display("FAIL busy_strobe got vv=%b val=%h want vv=1 val=7b", value_valid, value);
    else passed++;
    settle();
    checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL busy_events got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_directed();
    string dirs[9] = '{"256\n", "255\n", "1a2\0153\015", "0007\n",
                       "\015\n\015\n", " 42\n", "4 2\n", "x5\n", "099\015\n"};
    foreach (dirs[j]) play(dirs[j], 1);
    settle();
    checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL dir_count got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL dir_event%0d got %h want %h", k, got_q[k], exp_q[k]);
      else passed++;
    end
    checks++;
    if (value !== exp_value) $display("FAIL dir_value got %h want %h", value, exp_value);
    else passed++;
    checks++;
    if (err_code !== exp_code) $display("FAIL dir_code got %0d want %0d", err_code, exp_code);
    else passed++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midline();
    play("12", 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    line_q.delete();
    exp_value = 8'h00;
    exp_code = 2'd0;
    checks++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy);
    else passed++;
    play("9\n", 0);
    settle();
    checks++;
    if (got_q.size() !== 1 || exp_q.size() !== 1 || got_q[0] !== exp_q[0])
      $display("FAIL rstmid_events got n=%0d want n=1 value 09", got_q.size());
    else passed++;
    checks++;
    if (value !== 8'h09) $display("FAIL rstmid_value got %h want 09", value);
    else passed++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) send_random_line(2);
    settle();
    checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL rand_event%0d got %h want %h", k, got_q[k], exp_q[k]);
      else passed++;
    end
    checks++;
    if (value !== exp_value) $display("FAIL rand_value got %h want %h", value, exp_value);
    else passed++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 150; n++) send_random_line(0);
    settle();
    checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL b2b_event%0d got %h want %h", k, got_q[k], exp_q[k]);
      else passed++;
    end
    checks++;
    if (err_code !== exp_code) $display("FAIL b2b_code got %0d want %0d", err_code, exp_code);
    else passed++;
    got_q.delete();
    exp_q.delete();
  endtask

`ifdef UART_LINE_PARSER_HEX_EN
  task automatic test_hex();
    play("xA5\015x\015x1F3\015X0f\n", 1);
    settle();
    checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL hex_count got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL hex_event%0d got %h want %h", k, got_q[k], exp_q[k]);
      else passed++;
    end
    got_q.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_busy();
    test_directed();
    test_reset_midline();
    test_random();
    test_back_to_back();
`ifdef UART_LINE_PARSER_HEX_EN
    test_hex();
`endif
    checks++;
    if (both_cnt !== 0) $display("FAIL strobe_overlap got %0d want 0", both_cnt);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
